mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Parametrised load/store unit for the 5-stage MIPS pipeline; replaces the combinational sub-word write/read-extension logic in the mem/writeback stages.
- Accepts one memory operation at a time from the execute/mem boundary.
- Performs address-offset byte-lane alignment, byte strobes and sign/zero extension.
- Runs a valid/ack handshake to data memory with wait states and a bus timeout, reports misalignment/timeout exceptions, and drives a stall to the hazard unit while busy.

Parameters:
ADDR_W, 32, address width in bits (minimum 3).
TIMEOUT, 255, number of BUS-state cycles without dm_ack before a timeout exception is raised (minimum 1).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_fc  input  3  op code: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data (right-aligned)
req_wreg  input  5  destination register tag
flush  input  1  cancel the current or offered operation's writeback
stall  output  1  hazard-unit stall, 1 whenever state != IDLE
dm_en  output  1  memory request
dm_we  output  4  byte write strobes, 0000 for loads
dm_addr  output  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
dm_wdata  output  32  lane-replicated store data
dm_rdata  input  32  memory read data, valid with dm_ack
dm_ack  input  1  memory completion
resp_valid  output  1  one-cycle completion pulse
resp_regwrite  output  1  write resp_data to resp_wreg
resp_data  output  32  extended load result, 0 for stores
resp_wreg  output  5  latched req_wreg
exc_valid  output  1  one-cycle exception pulse
exc_code  output  2  01 load misaligned, 10 store misaligned, 11 bus timeout
exc_badaddr  output  ADDR_W  faulting byte address

Behaviour:
- Reset (asynchronous, rst=0): state IDLE; all outputs 0 except req_ready=1; timeout counter and cancel flag 0. Reset mid-transaction drops dm_en immediately; no response or exception is produced.
- Acceptance: a request is accepted on a rising edge when req_valid & req_ready & ~flush. flush has priority, so an offered request under flush is ignored. req_ready = (state==IDLE).
- Alignment check at acceptance:
  - Halfword ops with addr[0]=1 are misaligned.
  - Word ops with addr[1:0]!=0 are misaligned.
  - A misaligned request stays in IDLE and pulses exc_valid the next cycle, with exc_code 01 or 10 and exc_badaddr = req_addr. No bus access and no resp_valid.
- States:
  - IDLE: accepted aligned request latches fc, addr, wdata and wreg, then goes to BUS.
  - BUS: dm_en=1; dm_addr, dm_we and dm_wdata are held stable. On dm_ack, capture dm_rdata and go to RESP. If the counter reaches TIMEOUT without dm_ack, pulse the exception (code 11, exc_badaddr = latched address), drop dm_en and return to IDLE. The counter resets on entry to BUS.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency: request accepted at edge N gives dm_en high during cycle N+1. With dm_ack in cycle N+1+k, resp_valid is high in cycle N+2+k. The minimum is 2 cycles from acceptance to resp_valid.
- Store lanes (off = addr[1:0]):
  - SB: dm_wdata = {4{wdata[7:0]}}, dm_we = 0001<<off.
  - SH: dm_wdata = {2{wdata[15:0]}}, dm_we = 0011<<(2*addr[1]).
  - SW: dm_wdata = wdata, dm_we = 1111.
- Load extraction:
  - LB/LBU: byte at rdata[8*off+7:8*off], sign-extended or zero-extended.
  - LH/LHU: halfword at rdata[16*addr[1]+15:16*addr[1]], extension from bit 15 of the selected halfword.
  - LW: rdata unchanged.
- resp_regwrite = 1 for loads only, and 0 if cancelled.
- flush while in BUS or RESP sets the cancel flag. The bus transaction still completes (stores still write memory), resp_valid still pulses, and resp_regwrite is forced to 0. The flag clears on return to IDLE.
- Exceptions and responses are never asserted in the same cycle. dm_ack outside BUS is ignored.

Test Plan:
- LB at addr 0x1003, dm_rdata=0x80FF_1234, ack after 0 waits -> resp_valid at cycle 2, resp_data=0xFFFF_FF80, resp_regwrite=1. Same access as LBU -> resp_data=0x0000_0080.
- LH at 0x2002, dm_rdata=0x8001_7FFF, ack after 3 waits -> dm_en held 4 cycles, resp_valid at cycle 5, resp_data=0xFFFF_8001.
- SB 0xA5 at 0x3001 -> dm_we=0010, dm_wdata=0xA5A5_A5A5, dm_addr=0x3000, resp_regwrite=0. SH 0xBEEF at 0x3002 -> dm_we=1100.
- LW at 0x4002 -> exc_valid pulse, exc_code=01, exc_badaddr=0x4002, dm_en never rises. SH at 0x4001 -> exc_code=10.
- TIMEOUT=4 build, no dm_ack -> dm_en high for exactly 4 cycles, then exc_code=11, stall deasserts, req_ready=1.
- LW with flush asserted during BUS -> resp_valid pulses, resp_regwrite=0. rst pulled low mid-BUS -> dm_en=0, stall=0 immediately, no resp or exc afterwards.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS load/store unit with byte-lane alignment, load extension,
// a valid/ack data-memory handshake with bus timeout, and misalignment/timeout exceptions.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fc,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_wreg,
  input  logic              flush,
  output logic              stall,
  output logic              dm_en,
  output logic [3:0]        dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack,
  output logic              resp_valid,
  output logic              resp_regwrite,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_wreg,
  output logic              exc_valid,
  output logic [1:0]        exc_code,
  output logic [ADDR_W-1:0] exc_badaddr
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, stateNext;
  logic [CW-1:0] cnt;
  logic [2:0] fcQ;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0] wdataQ, rdataQ, loadData;
  logic [4:0] wregQ;
  logic cancel, accept, misalign, timeout, storeQ, signQ, storeBus;
  logic [1:0] reqSize, sizeQ;
  logic [7:0] byteSel;
  logic [15:0] halfSel;
  // access size: 0 byte, 1 halfword, 2 word
  function automatic logic [1:0] opSize(input logic [2:0] fc);
    return (fc == 3'b100 || fc == 3'b111) ? 2'd2 :
           (fc == 3'b010 || fc == 3'b011 || fc == 3'b110) ? 2'd1 : 2'd0;
  endfunction
  function automatic logic isStore(input logic [2:0] fc);
    return fc[2] & (fc[1] | fc[0]);
  endfunction
  always_comb begin
    reqSize = opSize(req_fc);
    accept = req_valid & (state == IDLE) & ~flush;
    misalign = reqSize == 2'd2 ? |req_addr[1:0] : reqSize == 2'd1 ? req_addr[0] : 1'b0;
    timeout = (state == BUS) & ~dm_ack & (cnt == CW'(TIMEOUT - 1));
    stateNext = state == IDLE ? ((accept & ~misalign) ? BUS : IDLE) :
                state == BUS ? (dm_ack ? RESP : timeout ? IDLE : BUS) : IDLE;
    req_ready = state == IDLE;
    stall = state != IDLE;
  end
  always_comb begin
    sizeQ = opSize(fcQ);
    storeQ = isStore(fcQ);
    signQ = ~fcQ[0] & ~fcQ[2];
    dm_en = state == BUS;
    storeBus = dm_en & storeQ;
    dm_addr = dm_en ? {addrQ[ADDR_W-1:2], 2'b00} : '0;
    dm_we = ~storeBus ? 4'b0000 : sizeQ == 2'd0 ? 4'b0001 << addrQ[1:0] :
            sizeQ == 2'd1 ? (addrQ[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dm_wdata = ~storeBus ? 32'h0 : sizeQ == 2'd0 ? {4{wdataQ[7:0]}} :
               sizeQ == 2'd1 ? {2{wdataQ[15:0]}} : wdataQ;
    byteSel = rdataQ[{addrQ[1:0], 3'b000} +: 8];
    halfSel = addrQ[1] ? rdataQ[31:16] : rdataQ[15:0];
    loadData = sizeQ == 2'd0 ? {{24{signQ & byteSel[7]}}, byteSel} :
               sizeQ == 2'd1 ? {{16{signQ & halfSel[15]}}, halfSel} : rdataQ;
    resp_valid = state == RESP;
    resp_data = (resp_valid & ~storeQ) ? loadData : 32'h0;
    resp_regwrite = resp_valid & ~storeQ & ~cancel & ~flush;
    resp_wreg = wregQ;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      fcQ <= '0;
      addrQ <= '0;
      wdataQ <= '0;
      rdataQ <= '0;
      wregQ <= '0;
      cancel <= 1'b0;
      exc_valid <= 1'b0;
      exc_code <= '0;
      exc_badaddr <= '0;
    end else begin
      state <= stateNext;
      cnt <= state == BUS ? cnt + 1'b1 : '0;
      cancel <= (stateNext != IDLE) & (cancel | (flush & (state != IDLE)));
      exc_valid <= (accept & misalign) | timeout;
      exc_code <= (accept & misalign) ? (isStore(req_fc) ? 2'b10 : 2'b01) : timeout ? 2'b11 : 2'b00;
      exc_badaddr <= (accept & misalign) ? req_addr : timeout ? addrQ : '0;
      if (accept & ~misalign) begin
        fcQ <= req_fc;
        addrQ <= req_addr;
        wdataQ <= req_wdata;
        wregQ <= req_wreg;
      end
      if ((state == BUS) & dm_ack) rdataQ <= dm_rdata;
    end
  end
endmodule
